bm_decode_accum: RTL and testbench
==================================

// Module: bm_decode_accum
// PURPOSE
//  Sequential erasure-decode datapath. Recovers one W-packet data group from K surviving groups.
//  Each input beat carries one surviving packet group and its WxW decode-bitmatrix block.
//  The beat is multiplied over GF(2^W) in bitmatrix form and XOR-accumulated.
//  After K beats the recovered group is presented on a valid/ready output until it is taken.
// PARAMETERS
//  K              2  surviving beats per recovered group (K >= 1)
//  W              4  GF word width; packets per group; bitmatrix is WxW
//  PACKET_LENGTH  2  bits per packet
// PORTS
//  clk          in   1                      clock, all state on rising edge
//  rst          in   1                      asynchronous, active-high reset
//  clear_i      in   1                      sync abort: drop partial/held result
//  in_valid     in   1                      input beat valid
//  in_ready     out  1                      block can accept a beat
//  in_bm_cols   in   [W-1:0] x [0:W-1]      decode bitmatrix columns for this beat
//  in_data      in   [PACKET_LENGTH-1:0] x [0:W-1]  surviving packet group
//  out_valid    out  1                      recovered group valid
//  out_ready    in   1                      downstream accepts recovered group
//  out_data     out  [PACKET_LENGTH-1:0] x [0:W-1]  recovered packet group
//  beat_cnt     out  $clog2(K+1)            beats accepted in the current group
// BEHAVIOUR
//  Product, combinational per beat: prod[j] = XOR over i of (in_data[i] & {PACKET_LENGTH{in_bm_cols[j][i]}}).
//  States:
//   ACCUM: in_ready=1, out_valid=0.
//   HOLD:  in_ready=0, out_valid=1.
//  Reset (async, rst=1):
//   state=ACCUM, beat_cnt=0, accumulator=0, out_valid=0, out_data=0.
//   in_ready=1 once the state is ACCUM.
//  Accept = in_valid & in_ready.
//   On accept with beat_cnt==0: acc <= prod. With beat_cnt>0: acc <= acc ^ prod.
//   On accept, beat_cnt++.
//  On the accept where beat_cnt==K-1: go to HOLD and set beat_cnt=K.
//   out_valid rises the cycle after the K-th accept, so latency is 1 cycle from the last beat.
//  HOLD: out_data = acc, held stable while out_valid & !out_ready. No input is accepted.
//  Output handshake (out_valid & out_ready): next cycle is ACCUM with beat_cnt=0.
//   The accumulator is not cleared; the next first beat overwrites it.
//   One bubble cycle exists between groups. Max throughput: 1 group per K+1 cycles.
//  clear_i=1 has priority over every other event in that cycle.
//   Next state is ACCUM, beat_cnt=0, acc=0, out_valid=0.
//   Any beat or output handshake in that cycle is discarded.
//  K==1: every accept goes straight to HOLD.
//  in_valid while in HOLD: ignored; the source holds its data because in_ready=0.
//  in_valid may drop between beats: beat_cnt and acc are held, with no timeout.
//  rst asserted mid-group or mid-HOLD: immediate return to reset values; the partial result is lost.
//  Widths are exact. No arithmetic carry; all combining is bitwise XOR/AND.
// TESTING (W=4, PACKET_LENGTH=2, K=2; index j=0..3)
//  1 Reset: assert rst mid-run -> out_valid=0, beat_cnt=0, in_ready=1 after release.
//  2 Beat1: cols[j]=1<<j, data={01,10,11,00}.
//    Beat2: cols[j]=4'b0001, data={10,xx,xx,xx}.
//    -> one cycle later out_valid=1, out_data={11,00,01,10}.
//  3 Hold out_ready=0 for 5 cycles after case 2 -> out_data stable, in_ready=0,
//    extra in_valid beats ignored. Then out_ready=1 -> next cycle in_ready=1, beat_cnt=0.
//  4 After 1 beat, pulse clear_i together with in_valid -> beat_cnt=0, acc=0.
//    The next 2 beats give only their own XOR, with no contribution from the cleared beat.
//  5 Back-to-back groups, in_valid=1 and out_ready=1 always
//    -> out_valid every 3rd cycle, results match the reference model.
//  6 Random beats vs reference model, 1000 groups, random valid/ready stalls
//    -> no mismatch, no lost or duplicated group.

Source files
------------

// File: rtl/bm_decode_accum.sv
// ---------------------------------------------------------------------------
// bm_decode_accum
//
// Sequential erasure-decode datapath. Each input beat carries one surviving
// packet group plus its WxW decode-bitmatrix block. The beat is multiplied
// over GF(2^W) in bitmatrix form, which reduces to an AND/XOR network. Each
// product is XOR-accumulated into the recovered group. After K beats the
// recovered group is offered on a valid/ready output and held until it is
// taken.
//
// Parameters
//   K              surviving beats per recovered group (K >= 1)
//   W              GF word width; packets per group; bitmatrix is WxW
//   PACKET_LENGTH  bits per packet
//
// Ports
//   clk         in   clock, all state on rising edge
//   rst         in   asynchronous active-high reset
//   clear_i     in   synchronous abort; drops any partial or held result
//   in_valid    in   input beat valid
//   in_ready    out  block can accept a beat (state ACCUM)
//   in_bm_cols  in   decode bitmatrix columns for this beat, [W-1:0] x W
//   in_data     in   surviving packet group, [PACKET_LENGTH-1:0] x W
//   out_valid   out  recovered group valid (state HOLD)
//   out_ready   in   downstream accepts the recovered group
//   out_data    out  recovered packet group, [PACKET_LENGTH-1:0] x W
//   beat_cnt    out  beats accepted in the current group
// ---------------------------------------------------------------------------
module bm_decode_accum #(
  parameter int K             = 2,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_bm_cols [0:W-1],
  input  logic [PACKET_LENGTH-1:0] in_data    [0:W-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACKET_LENGTH-1:0] out_data   [0:W-1],
  output logic [$clog2(K+1)-1:0]   beat_cnt
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(K - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                     r_state;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [CW-1:0]              r_beat_cnt;
  logic [PACKET_LENGTH-1:0]   r_acc  [0:W-1];

  logic [PACKET_LENGTH-1:0]   w_prod [0:W-1];
  logic                       w_accept;
  logic                       w_first;
  logic                       w_last;

  // Bitmatrix product: bit i of column j selects whether packet i
  // contributes to output packet j.
  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      w_prod[j] = '0;
      for (int i = 0; i < W; i++) begin
        w_prod[j] = w_prod[j] ^ (in_data[i] & {PACKET_LENGTH{in_bm_cols[j][i]}});
      end
    end
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_first  = (r_beat_cnt == '0);
  assign w_last   = (r_beat_cnt == LAST_BEAT);

  // Single FSM process. clear_i outranks every beat and handshake in its
  // cycle. The accumulator is not cleared on handshake: the first beat of
  // the next group overwrites it instead of XORing into it.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_beat_cnt  <= '0;
      // NOTE: the accumulator is reset because it drives out_data, which
      // must read zero after reset; it is small, so the reset costs little.
      for (int j = 0; j < W; j++) r_acc[j] <= '0;
    end else if (clear_i) begin
      r_state     <= ST_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_beat_cnt  <= '0;
      for (int j = 0; j < W; j++) r_acc[j] <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            for (int j = 0; j < W; j++) begin
              r_acc[j] <= w_first ? w_prod[j] : (r_acc[j] ^ w_prod[j]);
            end
            // On the last beat the increment lands exactly on K.
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (w_last) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= '0;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_beat_cnt  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_bm_decode_accum.sv
// ---------------------------------------------------------------------------
// tb_bm_decode_accum
//
// Self-checking bench for bm_decode_accum (K=2, W=4, PACKET_LENGTH=2).
// The reference keeps the accepted beats of the current group in a queue as
// GF(2) matrix-vector products; the expected group is the XOR of that queue.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at that same point.
// ---------------------------------------------------------------------------
module tb_bm_decode_accum;

  localparam int K  = 2;
  localparam int W  = 4;
  localparam int PL = 2;
  localparam int CW = $clog2(K + 1);
  localparam int GW = W * PL;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_i;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bm_cols [0:W-1];
  logic [PL-1:0] in_data    [0:W-1];
  logic          out_valid;
  logic          out_ready;
  logic [PL-1:0] out_data   [0:W-1];
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  bm_decode_accum #(.K(K), .W(W), .PACKET_LENGTH(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bm_cols (in_bm_cols),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .beat_cnt   (beat_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: products of accepted beats, and whether a group is held.
  logic [GW-1:0] m_beats [$];
  bit            m_hold  = 1'b0;
  int            m_done  = 0;

  // Product as a GF(2) matrix-vector multiply, one bit-plane at a time:
  // output bit b of packet j is the parity of column j masked by bit-plane b.
  function automatic logic [GW-1:0] ref_prod();
    logic [GW-1:0] r;
    logic [W-1:0]  plane;
    r = '0;
    for (int b = 0; b < PL; b++) begin
      for (int i = 0; i < W; i++) plane[i] = in_data[i][b];
      for (int j = 0; j < W; j++) r[j*PL + b] = ^(in_bm_cols[j] & plane);
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] ref_group();
    logic [GW-1:0] r;
    r = '0;
    foreach (m_beats[n]) r = r ^ m_beats[n];
    return r;
  endfunction

  function automatic logic [CW-1:0] ref_cnt();
    return m_hold ? CW'(K) : CW'(m_beats.size());
  endfunction

  function automatic logic [GW-1:0] dut_out();
    logic [GW-1:0] r;
    for (int j = 0; j < W; j++) r[j*PL +: PL] = out_data[j];
    return r;
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_hold = 1'b0;
  endtask

  // Advance one clock: update the reference from the inputs applied this
  // cycle, then wait for the edge and settle.
  task automatic tick();
    if (clear_i) begin
      model_reset();
    end else if (m_hold) begin
      if (out_ready) model_reset();
    end else if (in_valid) begin
      m_beats.push_back(ref_prod());
      if (m_beats.size() == K) begin
        m_hold = 1'b1;
        m_done++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    for (int j = 0; j < W; j++) begin
      in_bm_cols[j] = W'($urandom);
      in_data[j]    = PL'($urandom);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    // During the power-on reset.
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_vec++; if (beat_cnt !== '0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d exp 0", beat_cnt); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    n_vec++; if (dut_out() !== '0) begin n_err++; $display("FAIL reset_out_data: got %h exp 00", dut_out()); end
    rst = 1'b0;
    model_reset();

    // Reset in the middle of a group.
    rand_beat(); in_valid = 1'b1; tick();
    n_vec++; if (beat_cnt !== ref_cnt()) begin n_err++; $display("FAIL midgrp_beat_cnt: got %0d exp %0d", beat_cnt, ref_cnt()); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (beat_cnt !== '0) begin n_err++; $display("FAIL midgrp_rst_beat_cnt: got %0d exp 0", beat_cnt); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midgrp_rst_out_valid: got %b exp 0", out_valid); end
    #1 rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midgrp_rel_in_ready: got %b exp 1", in_ready); end

    // Reset while a result is held.
    in_valid = 1'b1;
    rand_beat(); tick();
    rand_beat(); tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL prehold_out_valid: got %b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_rst_out_valid: got %b exp 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_rst_in_ready: got %b exp 1", in_ready); end
    n_vec++; if (dut_out() !== '0) begin n_err++; $display("FAIL hold_rst_out_data: got %h exp 00", dut_out()); end
    #1 rst = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    out_ready = 1'b0;
    for (int j = 0; j < W; j++) in_bm_cols[j] = W'(1 << j);
    in_data[0] = 2'b01; in_data[1] = 2'b10; in_data[2] = 2'b11; in_data[3] = 2'b00;
    in_valid = 1'b1;
    tick();
    n_vec++; if (beat_cnt !== CW'(1)) begin n_err++; $display("FAIL basic_cnt1: got %0d exp 1", beat_cnt); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b exp 0", out_valid); end
    for (int j = 0; j < W; j++) in_bm_cols[j] = 4'b0001;
    rand_beat_data_keep0();
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %b exp 1", out_valid); end
    // Packets j=3..0 = 10,01,00,11.
    n_vec++; if (dut_out() !== 8'b10_01_00_11) begin n_err++; $display("FAIL basic_out_data: got %b exp 10010011", dut_out()); end
    n_vec++; if (dut_out() !== ref_group()) begin n_err++; $display("FAIL basic_model: got %h exp %h", dut_out(), ref_group()); end
  endtask

  // Second beat of the directed case: packet 0 is 10, the rest are don't-care.
  task automatic rand_beat_data_keep0();
    in_data[0] = 2'b10;
    for (int j = 1; j < W; j++) in_data[j] = PL'($urandom);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hold_stall();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_beat(); in_valid = 1'b1;
      tick();
      n_vec++; if (dut_out() !== 8'b10_01_00_11) begin n_err++; $display("FAIL stall_data c%0d: got %b exp 10010011", c, dut_out()); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready c%0d: got %b exp 0", c, in_ready); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid c%0d: got %b exp 1", c, out_valid); end
      n_vec++; if (beat_cnt !== CW'(K)) begin n_err++; $display("FAIL stall_beat_cnt c%0d: got %0d exp %0d", c, beat_cnt, K); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL take_in_ready: got %b exp 1", in_ready); end
    n_vec++; if (beat_cnt !== '0) begin n_err++; $display("FAIL take_beat_cnt: got %0d exp 0", beat_cnt); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL take_out_valid: got %b exp 0", out_valid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_clear();
    logic [GW-1:0] pa;
    logic [GW-1:0] pb;
    out_ready = 1'b0;
    rand_beat(); in_valid = 1'b1; tick();
    // clear_i together with a valid beat: the beat is discarded.
    rand_beat(); clear_i = 1'b1; tick();
    clear_i = 1'b0;
    n_vec++; if (beat_cnt !== '0) begin n_err++; $display("FAIL clear_beat_cnt: got %0d exp 0", beat_cnt); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL clear_in_ready: got %b exp 1", in_ready); end
    rand_beat(); pa = ref_prod(); tick();
    rand_beat(); pb = ref_prod(); tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL clear_after_valid: got %b exp 1", out_valid); end
    n_vec++; if (dut_out() !== (pa ^ pb)) begin n_err++; $display("FAIL clear_after_data: got %h exp %h", dut_out(), pa ^ pb); end

    // clear_i while held, with a handshake and a beat in the same cycle.
    out_ready = 1'b1; in_valid = 1'b1; rand_beat(); clear_i = 1'b1;
    tick();
    clear_i = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_hold_valid: got %b exp 0", out_valid); end
    n_vec++; if (beat_cnt !== '0) begin n_err++; $display("FAIL clear_hold_cnt: got %0d exp 0", beat_cnt); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    int last   = -1;
    int groups = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      rand_beat();
      n_vec++; if (out_valid !== m_hold) begin n_err++; $display("FAIL b2b_valid c%0d: got %b exp %b", c, out_valid, m_hold); end
      if (m_hold) begin
        n_vec++; if (dut_out() !== ref_group()) begin n_err++; $display("FAIL b2b_data c%0d: got %h exp %h", c, dut_out(), ref_group()); end
        if (last >= 0) begin
          n_vec++; if (c - last != K + 1) begin n_err++; $display("FAIL b2b_spacing c%0d: got %0d exp %0d", c, c - last, K + 1); end
        end
        last = c;
        groups++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++; if (groups != 10) begin n_err++; $display("FAIL b2b_groups: got %0d exp 10", groups); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    int taken = 0;
    int start = m_done;
    int exp_taken;
    for (int c = 0; c < 20000 && taken < 1000; c++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      n_vec++; if (in_ready !== !m_hold) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b exp %b", c, in_ready, !m_hold); end
      n_vec++; if (out_valid !== m_hold) begin n_err++; $display("FAIL rnd_out_valid c%0d: got %b exp %b", c, out_valid, m_hold); end
      n_vec++; if (beat_cnt !== ref_cnt()) begin n_err++; $display("FAIL rnd_beat_cnt c%0d: got %0d exp %0d", c, beat_cnt, ref_cnt()); end
      if (m_hold && out_ready) begin
        n_vec++; if (dut_out() !== ref_group()) begin n_err++; $display("FAIL rnd_data grp%0d: got %h exp %h", taken, dut_out(), ref_group()); end
        taken++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++; if (taken < 1000) begin n_err++; $display("FAIL rnd_timeout: got %0d groups exp 1000", taken); end
    exp_taken = m_done - start - (m_hold ? 1 : 0);
    n_vec++; if (taken != exp_taken) begin n_err++; $display("FAIL rnd_group_count: got %0d exp %0d", taken, exp_taken); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    clear_i   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < W; j++) begin
      in_bm_cols[j] = '0;
      in_data[j]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_hold_stall();
    test_clear();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
